// File: rtl/cic_comb_stream_if.sv
// Valid/ready stream bundle for the CIC comb: input side (i_*) and output side (o_*).
interface cic_comb_stream_if #(
    parameter int WIDTH = 30
);
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/cic_comb_stream.sv
// Streaming CIC comb y[n] = x[n] - x[n-DELAY] (mod 2^WIDTH) with one registered output stage.
// Optional CIC_COMB_PRIME_MASK_EN suppresses outputs for the first DELAY samples after reset/clear.
module cic_comb_stream #(
    parameter int WIDTH = 30,
    parameter int DELAY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    cic_comb_stream_if.slave bus
);
    logic [WIDTH-1:0] hist_q [DELAY];
    logic [WIDTH-1:0] hist_d [DELAY];
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] diff;
    logic             ready;
    logic             in_xfer;
    logic             load;

    assign ready   = ~(reset | clear) & (~valid_q | bus.o_tready);
    assign in_xfer = bus.i_tvalid & ready;
    assign diff    = bus.i_tdata - hist_q[DELAY-1];

`ifdef CIC_COMB_PRIME_MASK_EN
    localparam logic [2:0] PRIME_FULL = 3'(DELAY);
    logic [2:0] prime_q, prime_d;
    logic       primed;

    assign primed = (prime_q == PRIME_FULL);
    assign load   = in_xfer & primed;

    always_comb begin
        prime_d = prime_q;
        if (in_xfer && !primed) begin
            prime_d = prime_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prime_q <= 3'd0;
        end else begin
            prime_q <= prime_d;
        end
    end
`else
    assign load = in_xfer;
`endif

    // History counts accepted samples, not clocks.
    always_comb begin
        hist_d = hist_q;
        if (in_xfer) begin
            hist_d[0] = bus.i_tdata;
            for (int k = 1; k < DELAY; k++) begin
                hist_d[k] = hist_q[k-1];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = diff;
            last_d  = bus.i_tlast;
        end else if (bus.o_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int k = 0; k < DELAY; k++) begin
                hist_q[k] <= '0;
            end
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign bus.i_tready = ready;
    assign bus.o_tvalid = valid_q;
    assign bus.o_tdata  = data_q;
    assign bus.o_tlast  = last_q;
endmodule
